// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared declarations for the UART receive-side command path.
//   parser_state_t    : command frame parser states
//   SYNC_BYTE_DEFAULT : default frame start marker
//   frame_csum()      : frame checksum, address XOR data
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } parser_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                              input logic [7:0] data);
        return addr ^ data;
    endfunction

endpackage

// File: rtl/uart_fifo_reader.sv
// ---------------------------------------------------------------------------
// uart_fifo_reader
// Drains a FIFO one word per two cycles and presents each word as a
// one-cycle strobe.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : reads are allowed only while high
//   rdempty     : FIFO empty flag
//   q           : FIFO read data, valid the cycle after rdreq
//   rdreq       : FIFO read strobe, one-cycle pulse
//   byte_valid  : high for one cycle when byte_data holds a fresh word
//   byte_data   : the word read by the previous rdreq
// ---------------------------------------------------------------------------
module uart_fifo_reader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rdempty,
    input  logic [7:0] q,
    output logic       rdreq,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    // Handshake: a word is requested when the FIFO is non-empty and no
    // request was made last cycle; the FIFO returns it on q one cycle later,
    // and that cycle is flagged by byte_valid. Skipping the cycle after each
    // request gives the FIFO time to update rdempty, so it is never over-read.
    logic rdreq_q;

    assign rdreq      = en & ~rdreq_q & ~rdempty;
    assign byte_valid = rdreq_q;
    assign byte_data  = q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdreq_q <= 1'b0;
        end else begin
            rdreq_q <= rdreq;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
// Parses 4-byte command frames (sync, address, data, checksum) from the UART
// receive FIFO and issues one register write per valid frame. Bad checksums
// and stalled frames are dropped, flagged and counted.
//   clk, rst_n   : clock (also FIFO read clock), asynchronous active-low reset
//   rdempty, q   : RX FIFO empty flag and read data
//   rdreq        : RX FIFO read strobe
//   baud_gen_en  : baud generator enable, high from the first edge after reset
//   reg_addr/reg_data/reg_we : register write port, address/data held
//   frame_err    : one-cycle pulse on checksum error or timeout
//   err_count    : saturating error count
//   frame_count  : wrapping good-frame count
// ---------------------------------------------------------------------------
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdempty,
    input  logic [7:0] q,
    output logic       rdreq,
    output logic       baud_gen_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       reg_we,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic [7:0] frame_count
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    parser_state_t state, state_nxt;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic [7:0]    addr_lat, data_lat;
    logic [15:0]   tmo_cnt;
    logic          timeout;
    logic          we_nxt, err_nxt;

    uart_fifo_reader u_reader (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (baud_gen_en),
        .rdempty    (rdempty),
        .q          (q),
        .rdreq      (rdreq),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    assign timeout = (state != ST_SYNC) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // A captured byte takes priority over a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (byte_valid) begin
            case (state)
                ST_SYNC: if (byte_data == SYNC_BYTE) state_nxt = ST_ADDR;
                ST_ADDR: state_nxt = ST_DATA;
                ST_DATA: state_nxt = ST_CSUM;
                ST_CSUM: begin
                    state_nxt = ST_SYNC;
                    if (byte_data == frame_csum(addr_lat, data_lat)) begin
                        we_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: state_nxt = ST_SYNC;
            endcase
        end else if (timeout) begin
            state_nxt = ST_SYNC;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_gen_en <= 1'b0;
            addr_lat    <= '0;
            data_lat    <= '0;
            tmo_cnt     <= '0;
            reg_addr    <= '0;
            reg_data    <= '0;
            reg_we      <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
            frame_count <= '0;
        end else begin
            baud_gen_en <= 1'b1;
            reg_we      <= we_nxt;
            frame_err   <= err_nxt;

            if (byte_valid && state == ST_ADDR) addr_lat <= byte_data;
            if (byte_valid && state == ST_DATA) data_lat <= byte_data;

            if (byte_valid || state == ST_SYNC) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            if (we_nxt) begin
                reg_addr    <= addr_lat;
                reg_data    <= data_lat;
                frame_count <= frame_count + 8'd1;
            end

            if (err_nxt && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Bench for uart_cmd_ctrl: a queue-based RX FIFO, a frame-level reference
// model fed with every byte pushed, and a scoreboard of expected writes and
// expected error pulses (with their delay from the last FIFO read).
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    localparam int         T    = 20;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         DRAIN_LIMIT = 5000;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic       rdempty = 1'b1;
    logic [7:0] q       = 8'h00;
    logic       rdreq, baud_gen_en, reg_we, frame_err;
    logic [7:0] reg_addr, reg_data, err_count, frame_count;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(T), .SYNC_BYTE(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdempty     (rdempty),
        .q           (q),
        .rdreq       (rdreq),
        .baud_gen_en (baud_gen_en),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .reg_we      (reg_we),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .frame_count (frame_count)
    );

    // ---------------- RX FIFO model ----------------
    logic [7:0] fifo_q[$];
    always @(posedge clk) begin
        if (rdreq && fifo_q.size() > 0) q <= fifo_q.pop_front();
        rdempty <= (fifo_q.size() == 0);
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_wr_q[$];
    int          exp_err_q[$];
    logic [7:0]  part_q[$];
    int          good_total = 0;
    int          err_total  = 0;
    logic [7:0]  last_addr  = 8'h00;
    logic [7:0]  last_data  = 8'h00;
    int          push_total = 0;
    int          rd_total   = 0;
    int          rd_viol    = 0;
    int          last_rd_cyc = 0;
    logic        rdreq_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_byte(input logic [7:0] b);
        if (part_q.size() == 0) begin
            if (b == SYNC) part_q.push_back(b);
        end else begin
            part_q.push_back(b);
            if (part_q.size() == 4) begin
                if ((part_q[1] ^ part_q[2]) == part_q[3]) begin
                    exp_wr_q.push_back({part_q[1], part_q[2]});
                    last_addr = part_q[1];
                    last_data = part_q[2];
                    good_total++;
                end else begin
                    exp_err_q.push_back(2);
                    err_total++;
                end
                part_q.delete();
            end
        end
    endtask

    task automatic model_timeout();
        if (part_q.size() != 0) begin
            exp_err_q.push_back(T + 2);
            err_total++;
            part_q.delete();
        end
    endtask

    task automatic model_reset();
        part_q.delete();
        good_total = 0;
        err_total  = 0;
        last_addr  = 8'h00;
        last_data  = 8'h00;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [15:0] e;
        int d;
        if (reg_we) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                e = exp_wr_q.pop_front();
                check("we_addr_data", {reg_addr, reg_data}, e);
            end
            check("we_latency", cyc - last_rd_cyc, 2);
        end
        if (frame_err) begin
            if (exp_err_q.size() == 0) begin
                check("unexpected_err", 32'd1, 32'd0);
            end else begin
                d = exp_err_q.pop_front();
                check("err_latency", cyc - last_rd_cyc, d);
            end
        end
        if (rdreq) begin
            if (rdempty) rd_viol++;
            if (rdreq_prev) rd_viol++;
            rd_total++;
            last_rd_cyc = cyc;
        end
        rdreq_prev = rdreq;
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        fifo_q.push_back(b);
        push_total++;
        model_byte(b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input bit good);
        logic [7:0] c;
        c = a ^ d;
        if (!good) c = c ^ 8'($urandom_range(1, 255));
        push_byte(SYNC);
        push_byte(a);
        push_byte(d);
        push_byte(c);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || rdempty == 1'b0) && n < DRAIN_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", 32'(n < DRAIN_LIMIT), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic idle_timeout();
        model_timeout();
        repeat (T + 5) @(negedge clk);
    endtask

    task automatic phase_check(input string tag);
        check({tag, "_wr_left"}, exp_wr_q.size(), 0);
        check({tag, "_err_left"}, exp_err_q.size(), 0);
        check({tag, "_frame_count"}, frame_count, good_total % 256);
        check({tag, "_err_count"}, err_count, (err_total > 255) ? 255 : err_total);
        check({tag, "_reg_held"}, {reg_addr, reg_data}, {last_addr, last_data});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bits"}, {rdreq, baud_gen_en, reg_we, frame_err}, 4'b0000);
        check({tag, "_bytes"}, {reg_addr, reg_data, err_count, frame_count}, 32'h0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, "_baud_before_edge"}, baud_gen_en, 1'b0);
        @(negedge clk);
        check({tag, "_baud_after_edge"}, baud_gen_en, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rd_before;
        logic [7:0] b;
        int k;

        // Reset and outputs while in reset
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_reset("reset");

        // Empty FIFO: no reads at all
        rd_before = rd_total;
        repeat (30) @(negedge clk);
        check("empty_no_rdreq", rd_total - rd_before, 0);

        // Good frame
        send_frame(8'h12, 8'h34, 1'b1);
        drain();
        phase_check("good");
        check("good_addr", reg_addr, 8'h12);
        check("good_data", reg_data, 8'h34);

        // Bad checksum
        push_byte(SYNC); push_byte(8'h12); push_byte(8'h34); push_byte(8'h00);
        drain();
        phase_check("badcsum");
        check("badcsum_err_count", err_count, 8'd1);

        // Leading junk
        push_byte(8'h00); push_byte(8'hFF);
        push_byte(SYNC); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        drain();
        phase_check("junk");

        // Timeout mid-frame, then recovery
        push_byte(SYNC); push_byte(8'h12);
        drain();
        idle_timeout();
        phase_check("timeout");
        send_frame(8'h01, 8'h02, 1'b1);
        drain();
        phase_check("after_timeout");

        // Random frames with junk and occasional stalls
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                push_byte(b);
            end
            if ($urandom_range(0, 5) == 0) begin
                push_byte(SYNC);
                k = $urandom_range(0, 2);
                repeat (k) push_byte(8'($urandom_range(0, 255)));
                drain();
                idle_timeout();
            end
            send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       $urandom_range(0, 2) != 0);
        end
        drain();
        phase_check("rand_frames");

        // Raw random byte stream biased towards the sync marker
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) push_byte(SYNC);
            else push_byte(8'($urandom_range(0, 255)));
        end
        drain();
        idle_timeout();
        phase_check("rand_bytes");

        // Reset mid-frame with a byte left in the FIFO
        push_byte(SYNC); push_byte(8'h12);
        drain();
        @(negedge clk);
        fifo_q.push_back(8'h77);
        push_total++;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        release_reset("midreset");
        model_byte(8'h77);
        push_byte(SYNC); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        drain();
        phase_check("midreset");
        check("midreset_frame_count", frame_count, 8'd1);

        // Fresh reset, then counter limits
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        release_reset("limits");
        for (int i = 0; i < 256; i++) begin
            send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
        end
        drain();
        phase_check("wrap");
        check("wrap_frame_count", frame_count, 8'd0);
        for (int i = 0; i < 256; i++) begin
            send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        end
        drain();
        phase_check("saturate");
        check("saturate_err_count", err_count, 8'd255);

        // FIFO access discipline over the whole run
        check("rdreq_violations", rd_viol, 0);
        check("bytes_read", rd_total, push_total);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command controller on the receive side of the UART. It enables the baud generator after reset and drains the receive FIFO written by `uart_recv`. It parses 4-byte command frames (sync, address, data, checksum) and issues one register-write pulse per valid frame. Malformed or stalled frames are discarded and counted.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: number of `clk` cycles without a captured byte, while mid-frame, before the frame is abandoned.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; also the FIFO read clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rdempty`  in  1  RX FIFO empty flag.
- `q`  in  8  RX FIFO read data; valid the cycle after `rdreq`.
- `rdreq`  out  1  RX FIFO read strobe, 1-cycle pulse.
- `baud_gen_en`  out  1  baud generator enable.
- `reg_addr`  out  8  write address; held until the next write.
- `reg_data`  out  8  write data; held until the next write.
- `reg_we`  out  1  write strobe, 1-cycle pulse.
- `frame_err`  out  1  1-cycle pulse on a checksum error or a timeout.
- `err_count`  out  8  saturating error counter.
- `frame_count`  out  8  wrapping count of good frames.

## Operation
- **Reset values:** all outputs are 0. `baud_gen_en` goes to 1 on the first clock edge after `rst_n` is released and stays 1.
- **Fetch engine:**
  - If `rdreq` was not asserted last cycle and `rdempty`=0, assert `rdreq` for one cycle.
  - On the following cycle, capture `q` into the parser ("byte captured").
  - Maximum rate is one byte per 2 cycles. There are never back-to-back `rdreq` pulses, so an empty FIFO is never over-read.
- **Parser states:** SYNC, ADDR, DATA, CSUM.
  - SYNC: a captured byte equal to `SYNC_BYTE` moves to ADDR. Any other byte is dropped silently, with no error.
  - ADDR: the captured byte is latched as the address; move to DATA.
  - DATA: the captured byte is latched as the data; move to CSUM.
  - CSUM: if the byte equals address XOR data, go to SYNC, pulse `reg_we`, load `reg_addr`/`reg_data` and increment `frame_count` (mod 256). Otherwise go to SYNC, pulse `frame_err` and leave `reg_addr`/`reg_data` unchanged.
- **Timeout:**
  - A 16-bit cycle counter clears on every captured byte and while in SYNC, and increments otherwise.
  - When the counter reaches `TIMEOUT_CYCLES`-1 in ADDR, DATA or CSUM: go to SYNC and pulse `frame_err`. Any partial address/data is discarded.
  - If a byte is captured in the same cycle as the timeout, the byte wins: it is processed normally and the counter clears.
- **Error counter:** `err_count` increments on every `frame_err` pulse and saturates at 255.
- **Reset mid-frame:** an asynchronous reset returns the parser to SYNC with all outputs 0. The FIFO is not flushed, so leftover bytes are resynchronised through SYNC-state dropping.

## Timing
- Latency from a captured CSUM byte (cycle N) to the `reg_we` pulse: cycle N+1, registered.
- `reg_addr`/`reg_data` are valid in the same cycle as `reg_we`.
- `frame_err` is registered in the same way: one cycle after the CSUM byte capture or the timeout condition.
- `rdreq` depends only on registered state and `rdempty`, with no combinational path from `q`.

## Structure
- Shared package `uart_pkg`:
  - parser state enum;
  - `SYNC_BYTE` default;
  - checksum function (address XOR data).
- Natural sub-module: `uart_fifo_reader`, covering the `rdreq` pulse logic and the byte-captured strobe with its data. It is reusable by future FIFO consumers.
- Parser, timeout counter and statistics counters stay in the top level.

## Test plan
- **Good frame:** FIFO holds A5 12 34 26 -> one `reg_we` pulse with `reg_addr`=12, `reg_data`=34; `frame_count`=1; no `frame_err`.
- **Bad checksum:** A5 12 34 00 -> one `frame_err` pulse; `err_count`=1; no `reg_we`; `reg_addr`/`reg_data` keep their prior values.
- **Leading junk:** 00 FF A5 01 02 03 -> junk dropped without error; one `reg_we` with address 01, data 02.
- **Timeout:**
  - Set `TIMEOUT_CYCLES`=20 and send A5 12, then leave the FIFO empty for 25 cycles -> `frame_err` pulse and return to SYNC.
  - Then send A5 01 02 03 -> `reg_we` with address 01, data 02.
- **Empty FIFO and reset:**
  - With `rdempty`=1 throughout, `rdreq` never asserts.
  - Assert `rst_n`=0 after A5 12 -> all outputs 0 while in reset.
  - After release, `baud_gen_en`=1 one cycle later, and the next A5 01 02 03 is accepted.
- **Counter limits:**
  - 256 consecutive bad frames -> `err_count` saturates at 255.
  - 256 consecutive good frames -> `frame_count` wraps to 0.
